// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: state encoding and 8N1 framing.
package uart_receiver_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_START   = ST_START,
    S_DATA    = ST_DATA,
    S_STOP    = ST_STOP,
    S_RECOVER = ST_RECOVER
  } rx_state_e;

  // 8N1 frame
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Bit period shared with the transmitter so both ends agree
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer. The head is presented on data_o
// whenever the buffer is non-empty; data_o reads 0 when empty.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a push into a full buffer still lands
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage; contents are masked by empty_o so no reset is needed
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer, bit timing, deframing FSM
// and a small FWFT buffer read through the DATA/EMPTY/READ handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | line high, waiting for a falling edge
//   START   | timing to mid start bit to reject glitches
//   DATA    | sampling 8 data bits at mid bit, LSB first
//   STOP    | sampling stop bit; push / overrun / framing
//   RECOVER | after framing error, wait for line to go high
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SERIAL_IN,
  input  logic       RX_READ,
  output logic [7:0] RX_DATA,
  output logic       RX_EMPTY,
  output logic       FRAMING_ERROR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  logic          sync_q;
  logic          rx_s_q;
  rx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shreg_q;
  logic          ferr_q;
  logic          ovr_q;
  logic          busy_q;

  logic          bit_tick;
  logic          stop_ok;
  logic          push_w;
  logic          overrun_w;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_data;

  // Two-flop synchronizer; idles high so reset looks like a quiet line
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= SERIAL_IN;
      rx_s_q <= sync_q;
    end
  end

  // Stop-sample decode; a read in the same cycle makes room in a full buffer
  always_comb begin
    bit_tick  = (cnt_q == BIT_LAST);
    stop_ok   = (state_q == S_STOP) && bit_tick && rx_s_q && (idx_q == STOP_LAST);
    push_w    = stop_ok && (!fifo_full || RX_READ);
    overrun_w = stop_ok && fifo_full && !RX_READ;
  end

  // Deframing FSM with registered status outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_DATA;
              cnt_q   <= '0;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            shreg_q[idx_q] <= rx_s_q;
            cnt_q          <= '0;
            if (idx_q == DATA_LAST) begin
              state_q <= S_STOP;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              ferr_q  <= 1'b1;
              state_q <= S_RECOVER;
            end else if (idx_q == STOP_LAST) begin
              ovr_q   <= overrun_w;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RECOVER: begin
          // a held-low break stays here, so it yields only one error pulse
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push_w),
    .data_i  (shreg_q),
    .pop_i   (RX_READ),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign RX_DATA       = fifo_data;
  assign RX_EMPTY      = fifo_empty;
  assign FRAMING_ERROR = ferr_q;
  assign OVERRUN       = ovr_q;
  assign BUSY          = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit, 4-entry buffer.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam int T        = 16;
  localparam int STOP_OFS = 2 + T / 2 + 9 * T;   // 154
  localparam int RECOVER_OFS = (1 + DATA_BITS + STOP_BITS) * T + 2;  // line raised right after frame

  logic       CLK = 1'b0;
  logic       RESET;
  logic       SERIAL_IN;
  logic       RX_READ;
  logic [7:0] RX_DATA;
  logic       RX_EMPTY;
  logic       FRAMING_ERROR;
  logic       OVERRUN;
  logic       BUSY;

  uart_receiver #(.CLKS_PER_BIT(T), .FIFO_DEPTH(4)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .SERIAL_IN     (SERIAL_IN),
    .RX_READ       (RX_READ),
    .RX_DATA       (RX_DATA),
    .RX_EMPTY      (RX_EMPTY),
    .FRAMING_ERROR (FRAMING_ERROR),
    .OVERRUN       (OVERRUN),
    .BUSY          (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // event log sampled on the falling edge
  int         rise_q[$];
  int         fall_q[$];
  int         push_cyc_q[$];
  logic [7:0] push_dat_q[$];
  int         ferr_cnt = 0, ferr_cyc = -1, ovr_cnt = 0, ovr_cyc = -1;
  logic       busy_prev = 1'b0, empty_prev = 1'b1;

  always @(negedge CLK) begin
    if (BUSY && !busy_prev) rise_q.push_back(cyc);
    if (!BUSY && busy_prev) fall_q.push_back(cyc);
    if (!RX_EMPTY && empty_prev) begin
      push_cyc_q.push_back(cyc);
      push_dat_q.push_back(RX_DATA);
    end
    if (FRAMING_ERROR) begin ferr_cnt++; ferr_cyc = cyc; end
    if (OVERRUN) begin ovr_cnt++; ovr_cyc = cyc; end
    busy_prev  = BUSY;
    empty_prev = RX_EMPTY;
  end

  int n_run = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    rise_q.delete();
    fall_q.delete();
    push_cyc_q.delete();
    push_dat_q.delete();
    ferr_cnt = 0; ferr_cyc = -1;
    ovr_cnt  = 0; ovr_cyc  = -1;
  endtask

  // Leaves the line at the stop-bit level; t0 is the edge that first captures the start bit
  task automatic send_frame(input logic [7:0] b, input logic stop_b, output int t0);
    SERIAL_IN = 1'b0;
    t0 = cyc + 1;
    repeat (T) tick();
    for (int i = 0; i < 8; i++) begin
      SERIAL_IN = b[i];
      repeat (T) tick();
    end
    SERIAL_IN = stop_b;
    repeat (T) tick();
  endtask

  task automatic read_expect(input string name, input logic [7:0] exp);
    check({name, " not empty"}, {31'd0, RX_EMPTY}, 32'd0);
    check({name, " data"}, {24'd0, RX_DATA}, {24'd0, exp});
    RX_READ = 1'b1;
    tick();
    RX_READ = 1'b0;
  endtask

  task automatic expect_empty(input string name);
    check({name, " empty"}, {31'd0, RX_EMPTY}, 32'd1);
    check({name, " data zero"}, {24'd0, RX_DATA}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_push;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, ta, tb, t5, t6;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b1};

    RESET = 1'b1; SERIAL_IN = 1'b1; RX_READ = 1'b0;
    repeat (3) tick();
    check("reset BUSY", {31'd0, BUSY}, 32'd0);
    check("reset FERR", {31'd0, FRAMING_ERROR}, 32'd0);
    check("reset OVR", {31'd0, OVERRUN}, 32'd0);
    expect_empty("reset");
    RESET = 1'b0;
    repeat (5) tick();

    // back-to-back 0x55, 0xA3
    clear_log();
    send_frame(8'h55, 1'b1, ta);
    send_frame(8'hA3, 1'b1, tb);
    SERIAL_IN = 1'b1;
    repeat (20) tick();
    check("b2b rise count", rise_q.size(), 2);
    check("b2b fall count", fall_q.size(), 2);
    check("b2b busy rise 0", rise_q[0], ta + 2);
    check("b2b busy fall 0", fall_q[0], ta + STOP_OFS);
    check("b2b push cyc 0", push_cyc_q[0], ta + STOP_OFS);
    check("b2b push data 0", {24'd0, push_dat_q[0]}, 32'h55);
    check("b2b busy rise 1", rise_q[1], tb + 2);
    check("b2b busy fall 1", fall_q[1], tb + STOP_OFS);
    check("b2b pulses", ferr_cnt + ovr_cnt, 0);
    read_expect("b2b rd0", 8'h55);
    read_expect("b2b rd1", 8'hA3);
    expect_empty("b2b end");

    // table of single frames
    for (int i = 0; i < 5; i++) begin
      clear_log();
      send_frame(vecs[i].data, vecs[i].stop, t0);
      SERIAL_IN = 1'b1;
      repeat (20) tick();
      check($sformatf("vec%0d busy rise", i), rise_q[0], t0 + 2);
      check($sformatf("vec%0d push count", i), push_cyc_q.size(), {31'd0, vecs[i].exp_push});
      check($sformatf("vec%0d ferr count", i), ferr_cnt, {31'd0, vecs[i].exp_ferr});
      check($sformatf("vec%0d ovr count", i), ovr_cnt, 0);
      if (vecs[i].exp_push) begin
        check($sformatf("vec%0d push cyc", i), push_cyc_q[0], t0 + STOP_OFS);
        check($sformatf("vec%0d busy fall", i), fall_q[0], t0 + STOP_OFS);
        read_expect($sformatf("vec%0d rd", i), vecs[i].data);
      end else begin
        check($sformatf("vec%0d ferr cyc", i), ferr_cyc, t0 + STOP_OFS);
        check($sformatf("vec%0d busy fall", i), fall_q[0], t0 + RECOVER_OFS);
      end
      expect_empty($sformatf("vec%0d end", i));
    end

    // start-bit glitch
    clear_log();
    SERIAL_IN = 1'b0;
    t0 = cyc + 1;
    repeat (5) tick();
    SERIAL_IN = 1'b1;
    repeat (20) tick();
    check("glitch busy rise", rise_q[0], t0 + 2);
    check("glitch busy fall window",
          {31'd0, (fall_q.size() == 1 && fall_q[0] >= t0 + 3 && fall_q[0] <= t0 + 11)}, 32'd1);
    check("glitch no push", push_cyc_q.size(), 0);
    check("glitch no pulses", ferr_cnt + ovr_cnt, 0);

    // framing error followed by a held break, then 0x31
    clear_log();
    send_frame(8'h7E, 1'b0, t0);
    repeat (60) tick();
    check("break busy held", {31'd0, BUSY}, 32'd1);
    SERIAL_IN = 1'b1;
    repeat (20) tick();
    check("break ferr count", ferr_cnt, 1);
    check("break ferr cyc", ferr_cyc, t0 + STOP_OFS);
    check("break no push", push_cyc_q.size(), 0);
    check("break busy fall", fall_q[0], t0 + RECOVER_OFS + 60);
    send_frame(8'h31, 1'b1, t0);
    SERIAL_IN = 1'b1;
    repeat (20) tick();
    check("after break ferr count", ferr_cnt, 1);
    read_expect("after break rd", 8'h31);
    expect_empty("after break");

    // overrun on the fifth frame
    clear_log();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, t5);
    SERIAL_IN = 1'b1;
    repeat (20) tick();
    check("ovr count", ovr_cnt, 1);
    check("ovr cyc", ovr_cyc, t5 + STOP_OFS);
    check("ovr no ferr", ferr_cnt, 0);
    for (int i = 1; i <= 4; i++) read_expect($sformatf("ovr rd%0d", i), 8'(i));
    expect_empty("ovr end");

    // full buffer, read in the stop-sample cycle of 0x06
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, t0);
    SERIAL_IN = 1'b1;
    repeat (5) tick();
    clear_log();
    t6 = cyc + 1;
    fork
      send_frame(8'h06, 1'b1, t0);
      begin
        repeat (STOP_OFS) tick();
        RX_READ = 1'b1;
        tick();
        RX_READ = 1'b0;
      end
    join
    SERIAL_IN = 1'b1;
    repeat (20) tick();
    check("full frame start", t0, t6);
    check("full no ovr", ovr_cnt, 0);
    read_expect("full rd0", 8'h02);
    read_expect("full rd1", 8'h03);
    read_expect("full rd2", 8'h04);
    read_expect("full rd3", 8'h06);
    expect_empty("full end");

    // asynchronous reset during data bit 3
    send_frame(8'h42, 1'b1, t0);
    SERIAL_IN = 1'b1;
    repeat (10) tick();
    clear_log();
    fork
      send_frame(8'hF8, 1'b1, t0);
      begin
        repeat (71) tick();
        check("pre-reset busy", {31'd0, BUSY}, 32'd1);
        check("pre-reset not empty", {31'd0, RX_EMPTY}, 32'd0);
        RESET = 1'b1;
        #1;
        check("mid reset BUSY", {31'd0, BUSY}, 32'd0);
        check("mid reset FERR", {31'd0, FRAMING_ERROR}, 32'd0);
        check("mid reset OVR", {31'd0, OVERRUN}, 32'd0);
        expect_empty("mid reset");
        tick();
        tick();
        RESET = 1'b0;
      end
    join
    SERIAL_IN = 1'b1;
    repeat (20) tick();
    check("post reset no push", push_cyc_q.size(), 0);
    send_frame(8'hC9, 1'b1, t0);
    SERIAL_IN = 1'b1;
    repeat (20) tick();
    check("post reset push cyc", push_cyc_q[0], t0 + STOP_OFS);
    read_expect("post reset rd", 8'hC9);
    expect_empty("post reset end");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
